lcd_bank_sched: RTL and testbench
=================================

# lcd_bank_sched

Frame-buffer bank scheduler for the LCD video buffer. It owns the write pointer and the write bank used by the Game Boy pixel writer, and it selects which bank the video scanout reads each output frame. Modes are single-buffer, double-buffer with a read-ahead threshold, or triple-buffer (compile-time option). It sits between the PPU pixel stream and the frame-buffer RAM address inputs. The scanout frame-start strobe is already synchronised into `clk_sys`.

## Interface
- `PIX_PER_FRAME`, 23040: pixels per GB frame (160×144); `wr_ptr` saturation limit.
- `AHEAD_THRESH`, 9600: minimum `wr_ptr` at which the reader may share the bank in progress (double mode).
- `clk_sys`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `wr_pix`  in  1  pixel-write strobe, already qualified by `ce`.
- `wr_restart`  in  1  pulse: LCD on/off edge; zero the write pointer.
- `wr_frame_end`  in  1  pulse: writer finished a frame (VBlank entry / blank-frame wrap).
- `rd_frame_start`  in  1  pulse: scanout begins a new frame (line before first active line).
- `double_buffer`  in  1  0 = single-buffer (reader follows writer), 1 = buffered.
- `wr_bank`  out  2  bank currently written.
- `wr_ptr`  out  15  pixel index within `wr_bank`.
- `wr_ovf`  out  1  sticky: writes were attempted past `PIX_PER_FRAME`.
- `rd_bank`  out  2  bank currently scanned out.
- `drop_cnt`  out  8  saturating count of completed frames overwritten unread (triple mode only).

## Operation
- Reset values:
  - `wr_bank`=0, `rd_bank`=1, `wr_ptr`=0, `wr_ovf`=0, `drop_cnt`=0.
  - Internal `ready_valid`=0, `ready_bank`=0.
- Write pointer:
  - `wr_pix` increments `wr_ptr`. It saturates at `PIX_PER_FRAME`.
  - A `wr_pix` while `wr_ptr`==`PIX_PER_FRAME` sets `wr_ovf`, and `wr_ptr` stays at the limit.
  - `wr_restart` forces `wr_ptr`=0 and clears `wr_ovf`. It does not change banks.
- Frame commit (`wr_frame_end` with `wr_ptr`≠0):
  - `wr_ptr`←0 and `wr_ovf`←0.
  - The bank update depends on mode (see below).
  - A `wr_frame_end` with `wr_ptr`==0 is an empty frame and is ignored entirely.
- Double mode (default build):
  - Frame commit: `wr_bank`←`wr_bank`^1.
  - On `rd_frame_start`, `rd_bank`← `wr_ptr`≥`AHEAD_THRESH` ? `wr_bank` : `wr_bank`^1.
  - `wr_bank[1]` and `rd_bank[1]` are always 0.
- Single mode (`double_buffer`=0, either build): `rd_frame_start` sets `rd_bank`←`wr_bank`.
- Priority within a cycle:
  - Order: `wr_restart`/pixel increment, then frame commit, then reader decision.
  - The reader decision uses post-commit `wr_bank`, `wr_ptr` and `ready_*`.
  - `wr_pix` coinciding with a commit or restart is discarded; the pointer ends at 0.
- `reset` overrides everything on any cycle, including mid-frame.

## Timing
- All outputs are registered. Effects of any input pulse are visible on the cycle after the pulse.
- No handshakes: pulses are single-cycle and need no acknowledgement.
- A multi-cycle `wr_frame_end` acts on its first cycle; subsequent cycles see `wr_ptr`=0 and are ignored.
- A multi-cycle `rd_frame_start` re-evaluates every cycle; this is harmless because the decision is idempotent.
- `rd_bank` never changes except on `rd_frame_start` or `reset`, so scanout never switches banks mid-frame.

## Configuration
- `LCD_BANK_TRIPLE_EN` undefined: two banks, double mode as above, `drop_cnt` tied to 0.
- `LCD_BANK_TRIPLE_EN` defined: three banks (0–2), with triple buffering when `double_buffer`=1. The writer never writes `rd_bank`.
  - Frame commit: if `ready_valid`, `drop_cnt`++ (saturating at 255). Then `ready_bank`←`wr_bank`, `ready_valid`←1, `wr_bank`←3−`wr_bank`−`rd_bank` (using the pre-cycle `rd_bank`).
  - `rd_frame_start` with `ready_valid`: `rd_bank`←`ready_bank` and `ready_valid`←0.
  - `rd_frame_start` without `ready_valid`: `rd_bank` is held (repeat frame).
  - Single mode: unchanged, and `ready_valid` is cleared on every `rd_frame_start`.

## Test plan
- Reset: assert `reset` for 1 cycle mid-stream with `wr_ptr`=500 -> next cycle `wr_bank`=0, `rd_bank`=1, `wr_ptr`=0, `wr_ovf`=0, `drop_cnt`=0.
- Double mode read-ahead threshold:
  - 100 `wr_pix` then `wr_frame_end` -> `wr_bank`=1, `wr_ptr`=0.
  - 9600 `wr_pix` then `rd_frame_start` -> `rd_bank`=1.
  - Repeat the same sequence with 9599 pixels -> `rd_bank`=0.
- Saturation: 23041 `wr_pix` -> `wr_ptr`=23040, `wr_ovf`=1. `wr_frame_end` -> both cleared and `wr_bank` toggled.
- Empty frame and restart:
  - `wr_restart` then `wr_frame_end` with no pixels -> banks unchanged.
  - `wr_pix` and `wr_restart` in the same cycle -> `wr_ptr`=0.
- Triple mode (macro defined, `double_buffer`=1):
  - Commit frames in banks 0 then 2 with no read -> `drop_cnt`=1.
  - Then `rd_frame_start` -> `rd_bank`=2, and the next write bank is never 2.
- Simultaneous events (triple mode): `wr_frame_end` and `rd_frame_start` in the same cycle with `wr_bank`=0, `rd_bank`=1 -> `rd_bank`=0, `wr_bank`=2, `ready_valid`=0.

Source files
------------

// File: rtl/lcd_bank_sched.sv
// Frame-buffer bank scheduler: write pointer/bank for the pixel writer, read bank for scanout.
// Define LCD_BANK_TRIPLE_EN for three banks with triple buffering; default build is two banks.
module lcd_bank_sched #(
   parameter int PIX_PER_FRAME = 23040,
   parameter int AHEAD_THRESH  = 9600
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        wr_pix,
   input  logic        wr_restart,
   input  logic        wr_frame_end,
   input  logic        rd_frame_start,
   input  logic        double_buffer,
   output logic [1:0]  wr_bank,
   output logic [14:0] wr_ptr,
   output logic        wr_ovf,
   output logic [1:0]  rd_bank,
   output logic [7:0]  drop_cnt
);

   localparam logic [14:0] PTR_LIMIT = 15'(PIX_PER_FRAME);
   localparam logic [14:0] PTR_AHEAD = 15'(AHEAD_THRESH);

   logic [14:0] wr_ptr_q, wr_ptr_d;
   logic        wr_ovf_q, wr_ovf_d;
   logic [1:0]  wr_bank_q, wr_bank_d;
   logic [1:0]  rd_bank_q, rd_bank_d;
   logic        commit;

`ifdef LCD_BANK_TRIPLE_EN
   logic        ready_valid_q, ready_valid_d;
   logic [1:0]  ready_bank_q, ready_bank_d;
   logic [7:0]  drop_cnt_q, drop_cnt_d;
`endif

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      wr_ovf_d  = wr_ovf_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
`ifdef LCD_BANK_TRIPLE_EN
      ready_valid_d = ready_valid_q;
      ready_bank_d  = ready_bank_q;
      drop_cnt_d    = drop_cnt_q;
`endif
      // A restart empties the frame in progress, so a coincident frame end has nothing to commit.
      commit = wr_frame_end && (wr_ptr_q != '0) && !wr_restart;

      if (wr_restart || commit) begin
         wr_ptr_d = '0;
         wr_ovf_d = 1'b0;
      end else if (wr_pix) begin
         if (wr_ptr_q == PTR_LIMIT) wr_ovf_d = 1'b1;
         else                       wr_ptr_d = wr_ptr_q + 15'd1;
      end

      if (commit) begin
`ifdef LCD_BANK_TRIPLE_EN
         if (double_buffer) begin
            if (ready_valid_q && drop_cnt_q != 8'hff) drop_cnt_d = drop_cnt_q + 8'd1;
            ready_bank_d  = wr_bank_q;
            ready_valid_d = 1'b1;
            // The one bank that is neither being written nor scanned out.
            wr_bank_d     = 2'd3 - wr_bank_q - rd_bank_q;
         end else begin
            wr_bank_d = (wr_bank_q == 2'd2) ? 2'd0 : {1'b0, ~wr_bank_q[0]};
         end
`else
         wr_bank_d = {1'b0, ~wr_bank_q[0]};
`endif
      end

      if (rd_frame_start) begin
         if (!double_buffer) begin
            rd_bank_d = wr_bank_d;
`ifdef LCD_BANK_TRIPLE_EN
            ready_valid_d = 1'b0;
`endif
         end else begin
`ifdef LCD_BANK_TRIPLE_EN
            if (ready_valid_d) begin
               rd_bank_d     = ready_bank_d;
               ready_valid_d = 1'b0;
            end
`else
            // Far enough ahead: the reader can chase the writer within the same bank.
            rd_bank_d = (wr_ptr_d >= PTR_AHEAD) ? wr_bank_d : {1'b0, ~wr_bank_d[0]};
`endif
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         wr_ovf_q  <= 1'b0;
         wr_bank_q <= 2'd0;
         rd_bank_q <= 2'd1;
`ifdef LCD_BANK_TRIPLE_EN
         ready_valid_q <= 1'b0;
         ready_bank_q  <= 2'd0;
         drop_cnt_q    <= 8'd0;
`endif
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         wr_ovf_q  <= wr_ovf_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
`ifdef LCD_BANK_TRIPLE_EN
         ready_valid_q <= ready_valid_d;
         ready_bank_q  <= ready_bank_d;
         drop_cnt_q    <= drop_cnt_d;
`endif
      end
   end

   assign wr_ptr  = wr_ptr_q;
   assign wr_ovf  = wr_ovf_q;
   assign wr_bank = wr_bank_q;
   assign rd_bank = rd_bank_q;
`ifdef LCD_BANK_TRIPLE_EN
   assign drop_cnt = drop_cnt_q;
`else
   assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_lcd_bank_sched.sv
// Directed bench for lcd_bank_sched; covers the default build and, when LCD_BANK_TRIPLE_EN is set, triple mode.
module tb_lcd_bank_sched;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        wr_pix = 1'b0, wr_restart = 1'b0, wr_frame_end = 1'b0, rd_frame_start = 1'b0;
   logic        double_buffer = 1'b1;
   logic [1:0]  wr_bank, rd_bank;
   logic [14:0] wr_ptr;
   logic        wr_ovf;
   logic [7:0]  drop_cnt;

   int n_chk = 0;
   int n_err = 0;

   lcd_bank_sched dut (
      .clk_sys(clk_sys), .reset(reset), .wr_pix(wr_pix), .wr_restart(wr_restart),
      .wr_frame_end(wr_frame_end), .rd_frame_start(rd_frame_start), .double_buffer(double_buffer),
      .wr_bank(wr_bank), .wr_ptr(wr_ptr), .wr_ovf(wr_ovf), .rd_bank(rd_bank), .drop_cnt(drop_cnt)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic pix(input int n);
      wr_pix = 1'b1;
      repeat (n) tick();
      wr_pix = 1'b0;
   endtask

   task automatic frame_end();
      wr_frame_end = 1'b1;
      tick();
      wr_frame_end = 1'b0;
   endtask

   task automatic rd_start();
      rd_frame_start = 1'b1;
      tick();
      rd_frame_start = 1'b0;
   endtask

   logic [1:0] exp_bank;

   initial begin
      tick();
      do_reset();

      // Reset mid-stream
      pix(500);
      chk("ptr_before_reset", wr_ptr, 500);
      do_reset();
      chk("rst_wr_bank", wr_bank, 0);
      chk("rst_rd_bank", rd_bank, 1);
      chk("rst_wr_ptr", wr_ptr, 0);
      chk("rst_wr_ovf", wr_ovf, 0);
      chk("rst_drop_cnt", drop_cnt, 0);

      // Saturation and overflow
      pix(23041);
      chk("sat_wr_ptr", wr_ptr, 23040);
      chk("sat_wr_ovf", wr_ovf, 1);
      frame_end();
      chk("sat_commit_ptr", wr_ptr, 0);
      chk("sat_commit_ovf", wr_ovf, 0);
`ifdef LCD_BANK_TRIPLE_EN
      exp_bank = 2'd2;
`else
      exp_bank = 2'd1;
`endif
      chk("sat_commit_bank", wr_bank, exp_bank);

      // Empty frame after restart leaves banks alone
      do_reset();
      pix(7);
      wr_restart = 1'b1; tick(); wr_restart = 1'b0;
      chk("restart_ptr", wr_ptr, 0);
      frame_end();
      chk("empty_wr_bank", wr_bank, 0);
      chk("empty_rd_bank", rd_bank, 1);

      // Pixel coinciding with restart is discarded
      pix(3);
      wr_pix = 1'b1; wr_restart = 1'b1; tick();
      wr_pix = 1'b0; wr_restart = 1'b0;
      chk("pix_restart_ptr", wr_ptr, 0);
      chk("pix_restart_bank", wr_bank, 0);

      // Single mode: reader follows writer
      do_reset();
      double_buffer = 1'b0;
      pix(5);
      frame_end();
      chk("single_wr_bank", wr_bank, 1);
      chk("single_rd_hold", rd_bank, 1);
      frame_end();
      rd_start();
      chk("single_rd_follow", rd_bank, 1);
      pix(4); frame_end();
      rd_start();
      chk("single_rd_follow2", rd_bank, wr_bank);
      double_buffer = 1'b1;

`ifndef LCD_BANK_TRIPLE_EN
      // Read-ahead threshold, at and just below
      do_reset();
      pix(100);
      frame_end();
      chk("dbl_wr_bank", wr_bank, 1);
      chk("dbl_wr_ptr", wr_ptr, 0);
      pix(9600);
      rd_start();
      chk("dbl_ahead_rd", rd_bank, 1);
      do_reset();
      pix(100);
      frame_end();
      pix(9599);
      rd_start();
      chk("dbl_behind_rd", rd_bank, 0);
      chk("dbl_behind_ptr", wr_ptr, 9599);
      chk("dbl_drop_cnt", drop_cnt, 0);
`else
      // Unread frame is dropped, reader then takes the newest
      do_reset();
      pix(10); frame_end();
      chk("tri_bank_after_1", wr_bank, 2);
      chk("tri_drop_0", drop_cnt, 0);
      pix(10); frame_end();
      chk("tri_bank_after_2", wr_bank, 0);
      chk("tri_drop_1", drop_cnt, 1);
      rd_start();
      chk("tri_rd_newest", rd_bank, 2);
      pix(10); frame_end();
      chk("tri_wr_not_rd", wr_bank, 1);
      rd_start();
      chk("tri_rd_next", rd_bank, 0);
      rd_start();
      chk("tri_rd_repeat", rd_bank, 0);

      // Commit and read start together
      do_reset();
      pix(10);
      wr_frame_end = 1'b1; rd_frame_start = 1'b1; tick();
      wr_frame_end = 1'b0; rd_frame_start = 1'b0;
      chk("tri_sim_rd", rd_bank, 0);
      chk("tri_sim_wr", wr_bank, 2);
      rd_start();
      chk("tri_sim_ready_clr", rd_bank, 0);
      chk("tri_sim_drop", drop_cnt, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
